// File: rtl/imem_fetch_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | imem_fetch_pkg : reset/trap vectors, fetch FSM states, queue entry  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package imem_fetch_pkg;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam logic [31:0] IRQ_VEC  = 32'h8000_0004;
    localparam logic [31:0] EXC_VEC  = 32'h8000_0008;
    localparam int          QDEPTH   = 2;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2,
        ST_STEP = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    // Sequential successor: the kernel/user bit never changes by falling through.
    function automatic logic [31:0] seq_pc(input logic [31:0] pc);
        return {pc[31], pc[30:0] + 31'd4};
    endfunction

endpackage
`default_nettype wire

// File: rtl/imem_fetch_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | imem_fetch_ctrl_if : ROM, decode and redirect signals of the fetch  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
interface imem_fetch_ctrl_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_inst;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        exc_valid;
    logic        irq;
    logic        irq_ack;
    logic [31:0] epc;

    modport master (
        output imem_addr,
        input  imem_inst,
        output id_valid,
        input  id_ready,
        output id_inst,
        output id_pc,
        output id_pc4,
        input  redirect_valid,
        input  redirect_pc,
        input  exc_valid,
        input  irq,
        output irq_ack,
        output epc
    );

    modport slave (
        input  imem_addr,
        output imem_inst,
        input  id_valid,
        output id_ready,
        input  id_inst,
        input  id_pc,
        input  id_pc4,
        output redirect_valid,
        output redirect_pc,
        output exc_valid,
        output irq,
        input  irq_ack,
        input  epc
    );
endinterface
`default_nettype wire

// File: rtl/imem_fetch_ctrl_fetch_queue.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_queue : DEPTH-entry FIFO with flush, push+pop allowed when full|
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module fetch_queue
    import imem_fetch_pkg::*;
#(
    parameter int DEPTH = QDEPTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  fetch_entry_t din_i,
    output fetch_entry_t head_o,
    output logic [31:0]  next_pc_o,
    output logic         valid_o,
    output logic         full_o,
    output logic         multi_o
);

    localparam int            PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int            CW     = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] C_FULL = CW'(DEPTH);
    localparam logic [PW-1:0] C_LAST = PW'(DEPTH - 1);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] rd_q;
    logic [PW-1:0] wr_q;
    logic [CW-1:0] count_q;
    logic          w_push;
    logic          w_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == C_LAST) ? '0 : p + PW'(1);
    endfunction

    assign w_pop  = pop_i && (count_q != '0);
    // When full, a push is legal only because the head leaves in the same cycle.
    assign w_push = push_i && ((count_q != C_FULL) || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            if (w_push) begin
                mem_q[wr_q] <= din_i;
                wr_q        <= ptr_inc(wr_q);
            end
            if (w_pop) begin
                rd_q <= ptr_inc(rd_q);
            end
            if (w_push && !w_pop) begin
                count_q <= count_q + CW'(1);
            end else if (w_pop && !w_push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    assign head_o    = mem_q[rd_q];
    assign next_pc_o = mem_q[ptr_inc(rd_q)].pc;
    assign valid_o   = (count_q != '0);
    assign full_o    = (count_q == C_FULL);
    assign multi_o   = (count_q > CW'(1));

endmodule
`default_nettype wire

// File: rtl/imem_fetch_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | imem_fetch_ctrl : PC owner, ROM fetch, redirect/exc/irq arbitration |
// | Optional debug halt/step via IMEM_FETCH_STEP_EN.  Rev 1.0           |
// +--------------------------------------------------------------------+
module imem_fetch_ctrl
    import imem_fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
`ifdef IMEM_FETCH_STEP_EN
    input  logic              dbg_halt_i,
    input  logic              dbg_step_i,
`endif
    imem_fetch_ctrl_if.master bus
);

    fetch_state_e state_q;
    logic [31:0]  pc_q;
    logic [31:0]  pc_d;
    logic [31:0]  epc_q;
    logic [31:0]  epc_d;
    logic         irq_ack_q;

    fetch_entry_t w_head;
    fetch_entry_t w_din;
    logic [31:0]  w_next_pc;
    logic         w_qvalid;
    logic         w_qfull;
    logic         w_qmulti;
    logic         w_halt_req;
    logic         w_active;
    logic         w_run;
    logic         w_exc;
    logic         w_redir;
    logic         w_irq;
    logic         w_flush;
    logic         w_fetch_ok;
    logic         w_pop;
    logic         w_push;

`ifdef IMEM_FETCH_STEP_EN
    assign w_halt_req = dbg_halt_i;
`else
    assign w_halt_req = 1'b0;
`endif

    always_comb begin
        w_active   = (state_q != ST_BOOT);
        w_run      = (state_q == ST_RUN);
        w_pop      = w_qvalid && bus.id_ready;
        w_exc      = w_active && bus.exc_valid;
        w_redir    = w_active && !bus.exc_valid && bus.redirect_valid;
        w_irq      = w_run && !w_halt_req && !bus.exc_valid && !bus.redirect_valid
                     && bus.irq && !pc_q[31];
        w_flush    = w_exc || w_redir || w_irq;
        w_fetch_ok = (w_run && !w_halt_req) || (state_q == ST_STEP);
        w_push     = w_fetch_ok && !w_flush && (!w_qfull || w_pop);

        // Return to the oldest instruction decode has not yet consumed.
        if (w_qvalid && !w_pop) begin
            epc_d = w_head.pc;
        end else if (w_qmulti) begin
            epc_d = w_next_pc;
        end else begin
            epc_d = pc_q;
        end

        pc_d = pc_q;
        if (w_exc) begin
            pc_d = EXC_VEC;
        end else if (w_redir) begin
            pc_d = {bus.redirect_pc[31:2], 2'b00};
        end else if (w_irq) begin
            pc_d = IRQ_VEC;
        end else if (w_push) begin
            pc_d = seq_pc(pc_q);
        end
    end

    assign w_din = '{pc: pc_q, inst: bus.imem_inst};

    fetch_queue #(
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush_i   (w_flush),
        .push_i    (w_push),
        .pop_i     (w_pop),
        .din_i     (w_din),
        .head_o    (w_head),
        .next_pc_o (w_next_pc),
        .valid_o   (w_qvalid),
        .full_o    (w_qfull),
        .multi_o   (w_qmulti)
    );

    // irq_ack is registered, so it pulses in the cycle the IRQ vector and new epc appear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_BOOT;
            pc_q      <= RESET_PC;
            epc_q     <= '0;
            irq_ack_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            irq_ack_q <= w_irq;
            if (w_irq) begin
                epc_q <= epc_d;
            end
            case (state_q)
                ST_BOOT: state_q <= ST_RUN;
`ifdef IMEM_FETCH_STEP_EN
                ST_RUN: begin
                    if (dbg_halt_i) state_q <= ST_HALT;
                end
                ST_HALT: begin
                    if (!dbg_halt_i)     state_q <= ST_RUN;
                    else if (dbg_step_i) state_q <= ST_STEP;
                end
                ST_STEP: begin
                    if (w_push) state_q <= ST_HALT;
                end
`endif
                default: state_q <= ST_RUN;
            endcase
        end
    end

    assign bus.imem_addr = pc_q;
    assign bus.id_valid  = w_qvalid;
    assign bus.id_inst   = w_qvalid ? w_head.inst : '0;
    assign bus.id_pc     = w_qvalid ? w_head.pc : '0;
    assign bus.id_pc4    = w_qvalid ? (w_head.pc + 32'd4) : '0;
    assign bus.irq_ack   = irq_ack_q;
    assign bus.epc       = epc_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_imem_fetch_ctrl : directed vector table plus randomized run      |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_imem_fetch_ctrl;
    import imem_fetch_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    imem_fetch_ctrl_if bus();

`ifdef IMEM_FETCH_STEP_EN
    logic dbg_halt = 1'b0;
    logic dbg_step = 1'b0;
`endif

    imem_fetch_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef IMEM_FETCH_STEP_EN
        .dbg_halt_i (dbg_halt),
        .dbg_step_i (dbg_step),
`endif
        .bus        (bus)
    );

    function automatic logic [31:0] rom(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign bus.imem_inst = rom(bus.imem_addr);

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_out(input bit v, input logic [31:0] pc, input logic [31:0] addr,
                             input bit ack, input logic [31:0] epc);
        chk("imem_addr", bus.imem_addr, addr);
        chk("id_valid", {31'd0, bus.id_valid}, {31'd0, v});
        chk("irq_ack", {31'd0, bus.irq_ack}, {31'd0, ack});
        chk("epc", bus.epc, epc);
        if (v) begin
            chk("id_pc", bus.id_pc, pc);
            chk("id_inst", bus.id_inst, rom(pc));
            chk("id_pc4", bus.id_pc4, pc + 32'd4);
        end
    endtask

    typedef struct {
        bit          rst, rdy, exc, rdr, irq;
        logic [31:0] rpc;
        bit          v;
        logic [31:0] pc, addr;
        bit          ack;
        logic [31:0] epc;
    } vec_t;

    vec_t vt[$];

    task automatic add(input bit rst, input bit rdy, input bit exc, input bit rdr,
                       input logic [31:0] rpc, input bit irq, input bit v,
                       input logic [31:0] pc, input logic [31:0] addr,
                       input bit ack, input logic [31:0] epc);
        vec_t e;
        e.rst = rst; e.rdy = rdy; e.exc = exc; e.rdr = rdr; e.rpc = rpc; e.irq = irq;
        e.v = v; e.pc = pc; e.addr = addr; e.ack = ack; e.epc = epc;
        vt.push_back(e);
    endtask

    task automatic drive(input bit rdy, input bit exc, input bit rdr,
                         input logic [31:0] rpc, input bit irq);
        bus.id_ready       = rdy;
        bus.exc_valid      = exc;
        bus.redirect_valid = rdr;
        bus.redirect_pc    = rpc;
        bus.irq            = irq;
    endtask

    // Reference model state: PC, queued PCs toward decode, boot flag, irq bookkeeping.
    logic [31:0] m_pc;
    logic [31:0] m_epc;
    bit          m_ack;
    bit          m_boot;
    logic [31:0] mq[$];

    task automatic model_reset();
        m_pc = RESET_PC; m_epc = '0; m_ack = 1'b0; m_boot = 1'b1;
        mq.delete();
    endtask

    task automatic model_step();
        bit pop;
        pop   = (mq.size() != 0) && bus.id_ready;
        m_ack = 1'b0;
        if (m_boot) begin
            m_boot = 1'b0;
            return;
        end
        if (bus.exc_valid) begin
            mq.delete();
            m_pc = EXC_VEC;
        end else if (bus.redirect_valid) begin
            mq.delete();
            m_pc = {bus.redirect_pc[31:2], 2'b00};
        end else if (bus.irq && !m_pc[31]) begin
            if (pop) void'(mq.pop_front());
            m_epc = (mq.size() != 0) ? mq[0] : m_pc;
            mq.delete();
            m_pc  = IRQ_VEC;
            m_ack = 1'b1;
        end else begin
            if (pop) void'(mq.pop_front());
            if (mq.size() < QDEPTH) begin
                mq.push_back(m_pc);
                m_pc = {m_pc[31], m_pc[30:0] + 31'd4};
            end
        end
    endtask

    initial begin
        drive(0, 0, 0, '0, 0);

        // Seq A: straight-line fetch, exc beats redirect, kernel irq ignored, user irq taken
        add(1,1,0,0,32'h0,0,        0,32'h0,        32'h8000_0000,0,32'h0);
        add(0,1,0,0,32'h0,0,        0,32'h0,        32'h8000_0000,0,32'h0);
        add(0,1,0,0,32'h0,0,        0,32'h0,        32'h8000_0000,0,32'h0);
        add(0,1,0,0,32'h0,0,        1,32'h8000_0000,32'h8000_0004,0,32'h0);
        add(0,1,0,0,32'h0,0,        1,32'h8000_0004,32'h8000_0008,0,32'h0);
        add(0,1,1,1,32'h40,0,       1,32'h8000_0008,32'h8000_000C,0,32'h0);
        add(0,1,0,0,32'h0,1,        0,32'h0,        32'h8000_0008,0,32'h0);
        add(0,1,0,1,32'h10,0,       1,32'h8000_0008,32'h8000_000C,0,32'h0);
        add(0,1,0,0,32'h0,0,        0,32'h0,        32'h0000_0010,0,32'h0);
        add(0,0,0,0,32'h0,0,        1,32'h0000_0010,32'h0000_0014,0,32'h0);
        add(0,0,0,0,32'h0,1,        1,32'h0000_0010,32'h0000_0018,0,32'h0);
        add(0,1,0,0,32'h0,0,        0,32'h0,        32'h8000_0004,1,32'h10);
        add(0,1,0,0,32'h0,0,        1,32'h8000_0004,32'h8000_0008,0,32'h10);
        // Seq B: reset mid-run, stall to full, drain in order, redirect while full, 31-bit wrap
        add(1,0,0,0,32'h0,0,        0,32'h0,        32'h8000_0000,0,32'h0);
        add(0,0,0,0,32'h0,0,        0,32'h0,        32'h8000_0000,0,32'h0);
        add(0,0,0,0,32'h0,0,        0,32'h0,        32'h8000_0000,0,32'h0);
        add(0,0,0,0,32'h0,0,        1,32'h8000_0000,32'h8000_0004,0,32'h0);
        for (int i = 0; i < 4; i++)
            add(0,0,0,0,32'h0,0,    1,32'h8000_0000,32'h8000_0008,0,32'h0);
        add(0,1,0,0,32'h0,0,        1,32'h8000_0000,32'h8000_0008,0,32'h0);
        add(0,1,0,0,32'h0,0,        1,32'h8000_0004,32'h8000_000C,0,32'h0);
        add(0,0,0,0,32'h0,0,        1,32'h8000_0008,32'h8000_0010,0,32'h0);
        add(0,0,0,1,32'h40,0,       1,32'h8000_0008,32'h8000_0010,0,32'h0);
        add(0,1,0,0,32'h0,0,        0,32'h0,        32'h0000_0040,0,32'h0);
        add(0,1,0,0,32'h0,0,        1,32'h0000_0040,32'h0000_0044,0,32'h0);
        add(0,1,0,1,32'h7FFF_FFFC,0,1,32'h0000_0044,32'h0000_0048,0,32'h0);
        add(0,1,0,0,32'h0,0,        0,32'h0,        32'h7FFF_FFFC,0,32'h0);
        add(0,1,0,0,32'h0,0,        1,32'h7FFF_FFFC,32'h0000_0000,0,32'h0);
        add(0,1,0,0,32'h0,0,        1,32'h0000_0000,32'h0000_0004,0,32'h0);

        foreach (vt[i]) begin
            @(posedge clk); #1;
            rst_n = !vt[i].rst;
            drive(vt[i].rdy, vt[i].exc, vt[i].rdr, vt[i].rpc, vt[i].irq);
            @(negedge clk);
            check_out(vt[i].v, vt[i].pc, vt[i].addr, vt[i].ack, vt[i].epc);
        end

        // Randomized run against the reference model
        @(posedge clk); #1;
        rst_n = 1'b0;
        drive(0, 0, 0, '0, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] rpc;
            rpc = $urandom;
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 99) < 3,
                  $urandom_range(0, 99) < 6, rpc, $urandom_range(0, 9) < 2);
            @(negedge clk);
            check_out(mq.size() != 0, (mq.size() != 0) ? mq[0] : 32'h0, m_pc, m_ack, m_epc);
            model_step();
            @(posedge clk); #1;
        end

`ifdef IMEM_FETCH_STEP_EN
        begin
            int          n;
            logic [31:0] last_pc;
            n = 0;
            last_pc = '0;
            rst_n = 1'b0;
            drive(1, 0, 0, '0, 0);
            dbg_halt = 1'b1;
            @(posedge clk); #1;
            rst_n = 1'b1;
            for (int c = 0; c < 12; c++) begin
                dbg_step = (c == 2);
                @(negedge clk);
                if (bus.id_valid) begin
                    n++;
                    last_pc = bus.id_pc;
                end
                @(posedge clk); #1;
            end
            dbg_step = 1'b0;
            dbg_halt = 1'b0;
            chk("step_count", n, 32'd1);
            chk("step_pc", last_pc, RESET_PC);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imem_fetch_ctrl.md
# imem_fetch_ctrl

Instruction-fetch sequencer for the pipelined MIPS core. Owns the PC and drives the address of the combinational instruction ROM, which returns the instruction in the same cycle. Buffers fetched words in a small queue toward decode with a valid/ready handshake. Arbitrates PC redirects from exceptions, branches/jumps and interrupts; address bit 31 marks the kernel region.

## Interface
- RESET_PC, 32'h8000_0000, PC loaded at reset (kernel region)
- IRQ_VEC, 32'h8000_0004, interrupt handler address
- EXC_VEC, 32'h8000_0008, exception handler address
- QDEPTH, 2, fetch queue entries (≥1)
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- imem_addr  out  32  ROM address (= pc, combinational from pc register)
- imem_inst  in  32  ROM data, valid same cycle as imem_addr
- id_valid  out  1  queue head valid to decode
- id_ready  in  1  decode accepts head this cycle
- id_inst / id_pc / id_pc4  out  32 each  head instruction, its address, address+4
- redirect_valid  in  1  branch/jump taken (from ID/EX)
- redirect_pc  in  32  target
- exc_valid  in  1  exception raised downstream
- irq  in  1  level interrupt request
- irq_ack  out  1  one-cycle pulse when interrupt taken
- epc  out  32  return address captured on interrupt
- dbg_halt, dbg_step  in  1 each  (only with IMEM_FETCH_STEP_EN)

## Operation
- States: BOOT, RUN (+ HALT, STEP with macro). Reset → BOOT; BOOT → RUN after one cycle, no fetch in BOOT.
- RUN, per cycle, priority exc_valid > redirect_valid > irq > sequential.
- Sequential: enqueue {pc, imem_inst} when count<QDEPTH or (id_valid && id_ready); then pc[30:0] ← pc[30:0]+4 (wraps within 31 bits), pc[31] held. Queue full and no dequeue: pc holds, no enqueue.
- exc_valid: flush queue, no enqueue, pc ← EXC_VEC.
- redirect_valid: flush queue, no enqueue, pc ← {redirect_pc[31:2],2'b00}.
- irq taken only if irq && pc[31]==0 && no exc/redirect this cycle: epc ← head id_pc if queue non-empty (and not being dequeued), else next unissued pc; flush; pc ← IRQ_VEC; irq_ack=1 for that cycle. Not taken while pc[31]==1.
- Dequeue on id_valid && id_ready. Flush discards the cycle's dequeue output: id_valid=0 from next cycle.
- Reset mid-operation: pc=RESET_PC, queue empty, state BOOT, epc=0, all outputs 0 except imem_addr=RESET_PC.

## Timing
- Reset release → first id_valid at 2nd rising edge (BOOT, then fetch at RESET_PC).
- Redirect/exc/irq seen in cycle N → target on imem_addr in N+1 → id_valid with target in N+2. Penalty: 2 cycles.
- Steady state with id_ready=1: one instruction per cycle.
- id_* outputs come from registers; no combinational path from id_ready or redirect inputs to id_*.

## Configuration
- IMEM_FETCH_STEP_EN defined: dbg_halt/dbg_step ports exist. RUN → HALT when dbg_halt=1 (no fetch, queue drains normally). HALT: dbg_step pulse → STEP: exactly one enqueue, then HALT. HALT → RUN when dbg_halt=0. Redirect/exc still update pc in HALT; irq ignored in HALT.
- Undefined: ports absent, FSM is BOOT/RUN only.

## Structure
- Package imem_fetch_pkg: default vectors, state enum, queue entry struct {pc, inst}.
- Sub-module fetch_queue: QDEPTH-entry synchronous FIFO with flush, count, simultaneous push/pop when full.

## Test plan
- Reset release, id_ready=1 → id_pc 0x8000_0000, 0x8000_0004, 0x8000_0008 on consecutive cycles starting 2nd edge.
- id_ready=0 for 5 cycles → queue fills with 2 entries, pc stalls at RESET_PC+8; release → entries in order, no loss or duplication.
- redirect_pc=0x0000_0040 while full → flush, id_pc 0x0000_0040 two cycles later.
- pc=0x0000_0010, irq=1 → irq_ack pulse, epc=head pc, next id_pc 0x8000_0004; irq=1 with pc[31]=1 → ignored.
- exc_valid and redirect_valid same cycle → EXC_VEC wins; pc 0x7FFF_FFFC sequential → 0x0000_0000.
- (macro) dbg_halt=1 then dbg_step pulse → exactly one new instruction enqueued.
